decode_stage_hz: RTL and testbench
==================================

Name: decode_stage_hz

Overview:
Parametrised next-generation decode stage for the 5-stage RISC-V pipeline. It holds the architectural register file and resolves all conditional branches and jumps in decode. The full branch set is supported, with operand forwarding from MEM. It detects load-use and branch-operand hazards and drives stall and flush. It also owns the ID/EX pipeline register, which carries a valid bit and has stall-bubble and flush control. Instruction decode and immediate generation stay external; their outputs enter as a control bundle plus flags.

Parameters:
XLEN, 64, datapath width.
NREGS, 32, register count; address width RW = clog2(NREGS).
CTRL_W, 12, width of the opaque control bundle passed from ID to EX.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
valid_d  in  1  IF/ID holds a real instruction
instr_d  in  32  instruction; rs1=[19:15], rs2=[24:20], rd=[11:7], funct3=[14:12]
pc_d, pc_plus4_d  in  XLEN  PC and PC+4 of the decode instruction
imm_d  in  XLEN  sign-extended immediate for the decode instruction
ctrl_d  in  CTRL_W  decoded control bundle, passed through untouched
reg_we_d, mem_read_d  in  1  decoded register-write and load flags
use_rs1_d, use_rs2_d  in  1  instruction reads rs1 / rs2
is_branch_d, is_jal_d, is_jalr_d  in  1  control-flow class
reg_we_m, mem_read_m  in  1  MEM-stage write and load flags
rd_m  in  RW  MEM-stage destination
alu_result_m  in  XLEN  MEM-stage ALU result
reg_we_w  in  1  writeback enable
rd_w  in  RW  writeback destination
result_w  in  XLEN  writeback data
flush_e  in  1  external kill of the ID/EX slot
stall_fd  out  1  hold PC and IF/ID this cycle
pc_src_d  out  1  redirect fetch to pc_target_d
pc_target_d  out  XLEN  redirect target
flush_fd  out  1  kill IF/ID next cycle; equals pc_src_d
valid_e, reg_we_e, mem_read_e  out  1  ID/EX register outputs
ctrl_e  out  CTRL_W  ID/EX register output
rd_e, rs1_e, rs2_e  out  RW  ID/EX register outputs
rd1_e, rd2_e, imm_e, pc_plus4_e  out  XLEN  ID/EX register outputs

Behaviour:
- Register file
  - NREGS x XLEN; write on posedge clk when reg_we_w and rd_w!=0.
  - x0 always reads 0.
  - Reads are combinational, with W bypass: if reg_we_w and rd_w==rs and rs!=0, the read returns result_w.
  - rst clears all entries asynchronously.
- Branch operands (per source)
  - Use alu_result_m if reg_we_m, !mem_read_m, rd_m==rs and rs!=0.
  - Otherwise use the register-file read.
  - MEM forwarding has priority over W bypass.
- Branch condition by funct3
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 are never taken.
- Hazard (combinational; stall_fd = hz)
  - hz = valid_d and (loaduse or brhaz).
  - loaduse: valid_e, mem_read_e, rd_e!=0, and rd_e matches a used rs.
  - brhaz applies when is_branch_d or is_jalr_d:
    - (valid_e, reg_we_e, rd_e!=0, rd_e matches a used rs), or
    - (reg_we_m, mem_read_m, rd_m!=0, rd_m matches a used rs).
- Redirect
  - pc_src_d = valid_d and !hz and (is_jal_d or is_jalr_d or (is_branch_d and taken)).
  - JALR target = (fwd_rs1 + imm_d) with bit 0 cleared.
  - Other targets = pc_d + imm_d, mod 2^XLEN.
  - pc_target_d is don't-care when pc_src_d=0.
- ID/EX register (posedge clk; rst async clears every output to 0)
  - Priority: rst > flush_e > hz or !valid_d (bubble) > load.
  - Bubble or flush: valid_e, reg_we_e, mem_read_e and ctrl_e go to 0; the other fields are don't-care but zeroed.
  - Load: every _e output takes its _d source.
    - rd1_e/rd2_e take the register-file reads with W bypass only. EX forwarding handles the rest.
    - rs1_e/rs2_e take the instruction fields.
  - A taken redirect still loads the jump/branch into EX, so JAL/JALR write the link register.
- Simultaneous events
  - hz and a would-be redirect: hz wins, pc_src_d=0.
  - flush_e with hz: the slot is bubbled and stall_fd stays asserted.
  - rst mid-stall releases the stall (outputs are 0).
- Latency
  - Decode to EX outputs: 1 cycle.
  - Redirect: same cycle; costs 1 fetch bubble.

Test Plan:
- Reset: assert rst mid-run → every output 0 and x1..x31 read 0. Write x0=5 → x0 still reads 0.
- W bypass: writeback x3=0x1234 in the same cycle decode reads rs1=3 → rd1_e=0x1234 next cycle.
- Load-use: EX holds a load to x5 (valid_e=1); decode is add rs1=5 → stall_fd=1, next cycle valid_e=0 and reg_we_e=0. The following cycle the add loads.
- MEM forwarding: blt x1,x2 with x1=-1 from alu_result_m and RF x2=1 → pc_src_d=1, pc_target_d=pc_d+imm_d. With bltu on the same operands → pc_src_d=0.
- Branch hazard: beq rs1=7 while EX writes x7 → one-cycle stall. Then the value forwards from MEM and the branch resolves.
- JALR: rs1=0x1001, imm_d=4 → pc_target_d=0x1004, flush_fd=1, and next cycle valid_e=1, reg_we_e=1.
- flush_e coincident with a valid load → valid_e=0, ctrl_e=0.

Source files
------------

// File: rtl/decode_stage_hz.sv
// Decode stage: register file, branch/jump resolution with MEM forwarding,
// load-use and branch-operand hazard detection, and the ID/EX pipeline register.
module decode_stage_hz #(
   parameter int XLEN   = 64,
   parameter int NREGS  = 32,
   parameter int CTRL_W = 12,
   localparam int RW    = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_d,
   input  logic [31:0]       instr_d,
   input  logic [XLEN-1:0]   pc_d,
   input  logic [XLEN-1:0]   pc_plus4_d,
   input  logic [XLEN-1:0]   imm_d,
   input  logic [CTRL_W-1:0] ctrl_d,
   input  logic              reg_we_d,
   input  logic              mem_read_d,
   input  logic              use_rs1_d,
   input  logic              use_rs2_d,
   input  logic              is_branch_d,
   input  logic              is_jal_d,
   input  logic              is_jalr_d,
   input  logic              reg_we_m,
   input  logic              mem_read_m,
   input  logic [RW-1:0]     rd_m,
   input  logic [XLEN-1:0]   alu_result_m,
   input  logic              reg_we_w,
   input  logic [RW-1:0]     rd_w,
   input  logic [XLEN-1:0]   result_w,
   input  logic              flush_e,
   output logic              stall_fd,
   output logic              pc_src_d,
   output logic [XLEN-1:0]   pc_target_d,
   output logic              flush_fd,
   output logic              valid_e,
   output logic              reg_we_e,
   output logic              mem_read_e,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic [RW-1:0]     rd_e,
   output logic [RW-1:0]     rs1_e,
   output logic [RW-1:0]     rs2_e,
   output logic [XLEN-1:0]   rd1_e,
   output logic [XLEN-1:0]   rd2_e,
   output logic [XLEN-1:0]   imm_e,
   output logic [XLEN-1:0]   pc_plus4_e
);

   logic [XLEN-1:0] regs [NREGS];
   logic [RW-1:0]   rs1, rs2, rd;
   logic [2:0]      funct3;
   logic            unused_bits;

   assign rs1    = instr_d[15 +: RW];
   assign rs2    = instr_d[20 +: RW];
   assign rd     = instr_d[7 +: RW];
   assign funct3 = instr_d[14:12];
   assign unused_bits = ^{instr_d[31:25], instr_d[6:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (reg_we_w && rd_w != '0) begin
         regs[rd_w] <= result_w;
      end
   end

   // rf*: register read with same-cycle writeback bypass (what EX receives).
   // src*: rf* overridden by a non-load MEM result, used only for branch resolution.
   logic [XLEN-1:0] rf1, rf2, src1, src2;

   always_comb begin
      rf1 = regs[rs1];
      if (rs1 == '0) rf1 = '0;
      else if (reg_we_w && rd_w == rs1) rf1 = result_w;
      rf2 = regs[rs2];
      if (rs2 == '0) rf2 = '0;
      else if (reg_we_w && rd_w == rs2) rf2 = result_w;
   end

   assign src1 = (reg_we_m && !mem_read_m && rd_m == rs1 && rs1 != '0) ? alu_result_m : rf1;
   assign src2 = (reg_we_m && !mem_read_m && rd_m == rs2 && rs2 != '0) ? alu_result_m : rf2;

   logic taken;

   always_comb begin
      case (funct3)
         3'b000:  taken = (src1 == src2);
         3'b001:  taken = (src1 != src2);
         3'b100:  taken = ($signed(src1) <  $signed(src2));
         3'b101:  taken = ($signed(src1) >= $signed(src2));
         3'b110:  taken = (src1 <  src2);
         3'b111:  taken = (src1 >= src2);
         default: taken = 1'b0;
      endcase
   end

   logic uses_e, uses_m, loaduse, brhaz, hz;

   assign uses_e  = (rd_e != '0) && ((use_rs1_d && rd_e == rs1) || (use_rs2_d && rd_e == rs2));
   assign uses_m  = (rd_m != '0) && ((use_rs1_d && rd_m == rs1) || (use_rs2_d && rd_m == rs2));
   assign loaduse = valid_e && mem_read_e && uses_e;
   // Branches and JALR resolve here, so a producer still in EX, or a load in MEM, is too late.
   assign brhaz   = (is_branch_d || is_jalr_d) &&
                    ((valid_e && reg_we_e && uses_e) || (reg_we_m && mem_read_m && uses_m));
   assign hz      = valid_d && (loaduse || brhaz);

   assign stall_fd = hz;
   assign pc_src_d = valid_d && !hz && (is_jal_d || is_jalr_d || (is_branch_d && taken));
   assign flush_fd = pc_src_d;

   logic [XLEN-1:0] jalr_sum;

   assign jalr_sum    = src1 + imm_d;
   assign pc_target_d = is_jalr_d ? {jalr_sum[XLEN-1:1], 1'b0} : (pc_d + imm_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_e    <= 1'b0;
         reg_we_e   <= 1'b0;
         mem_read_e <= 1'b0;
         ctrl_e     <= '0;
         rd_e       <= '0;
         rs1_e      <= '0;
         rs2_e      <= '0;
         rd1_e      <= '0;
         rd2_e      <= '0;
         imm_e      <= '0;
         pc_plus4_e <= '0;
      end else if (flush_e || hz || !valid_d) begin
         valid_e    <= 1'b0;
         reg_we_e   <= 1'b0;
         mem_read_e <= 1'b0;
         ctrl_e     <= '0;
         rd_e       <= '0;
         rs1_e      <= '0;
         rs2_e      <= '0;
         rd1_e      <= '0;
         rd2_e      <= '0;
         imm_e      <= '0;
         pc_plus4_e <= '0;
      end else begin
         valid_e    <= 1'b1;
         reg_we_e   <= reg_we_d;
         mem_read_e <= mem_read_d;
         ctrl_e     <= ctrl_d;
         rd_e       <= rd;
         rs1_e      <= rs1;
         rs2_e      <= rs2;
         rd1_e      <= rf1;
         rd2_e      <= rf2;
         imm_e      <= imm_d;
         pc_plus4_e <= pc_plus4_d;
      end
   end

endmodule

// File: tb/tb_decode_stage_hz.sv
// Bench for decode_stage_hz: branch-condition table, directed hazard/forwarding
// sequences, and randomized cycles checked against a behavioural model.
module tb_decode_stage_hz;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_d;
   logic [31:0] instr_d;
   logic [63:0] pc_d, pc_plus4_d, imm_d;
   logic [11:0] ctrl_d;
   logic        reg_we_d, mem_read_d, use_rs1_d, use_rs2_d;
   logic        is_branch_d, is_jal_d, is_jalr_d;
   logic        reg_we_m, mem_read_m;
   logic [4:0]  rd_m;
   logic [63:0] alu_result_m;
   logic        reg_we_w;
   logic [4:0]  rd_w;
   logic [63:0] result_w;
   logic        flush_e;
   logic        stall_fd, pc_src_d, flush_fd;
   logic [63:0] pc_target_d;
   logic        valid_e, reg_we_e, mem_read_e;
   logic [11:0] ctrl_e;
   logic [4:0]  rd_e, rs1_e, rs2_e;
   logic [63:0] rd1_e, rd2_e, imm_e, pc_plus4_e;

   int checks = 0;
   int failures = 0;

   decode_stage_hz #(.XLEN(64), .NREGS(32), .CTRL_W(12)) dut (
      .clk(clk), .rst(rst), .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d),
      .pc_plus4_d(pc_plus4_d), .imm_d(imm_d), .ctrl_d(ctrl_d), .reg_we_d(reg_we_d),
      .mem_read_d(mem_read_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
      .is_branch_d(is_branch_d), .is_jal_d(is_jal_d), .is_jalr_d(is_jalr_d),
      .reg_we_m(reg_we_m), .mem_read_m(mem_read_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
      .reg_we_w(reg_we_w), .rd_w(rd_w), .result_w(result_w), .flush_e(flush_e),
      .stall_fd(stall_fd), .pc_src_d(pc_src_d), .pc_target_d(pc_target_d), .flush_fd(flush_fd),
      .valid_e(valid_e), .reg_we_e(reg_we_e), .mem_read_e(mem_read_e), .ctrl_e(ctrl_e),
      .rd_e(rd_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd1_e(rd1_e), .rd2_e(rd2_e),
      .imm_e(imm_e), .pc_plus4_e(pc_plus4_e)
   );

   // clock
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        valid, reg_we, mem_read;
      logic [11:0] ctrl;
      logic [4:0]  rd, rs1, rs2;
      logic [63:0] rd1, rd2, imm, pc4;
   } ex_t;

   logic [63:0] m_rf [32];
   ex_t         m_ex;

   function automatic logic [63:0] m_read(input logic [4:0] r);
      if (r == 0) return 64'd0;
      if (reg_we_w && rd_w == r) return result_w;
      return m_rf[r];
   endfunction

   function automatic logic [63:0] m_operand(input logic [4:0] r);
      if (r != 0 && reg_we_m && !mem_read_m && rd_m == r) return alu_result_m;
      return m_read(r);
   endfunction

   function automatic logic m_reads(input logic [4:0] r);
      return (r != 0) && ((use_rs1_d && r == instr_d[19:15]) || (use_rs2_d && r == instr_d[24:20]));
   endfunction

   function automatic logic m_hazard();
      logic lu, bh;
      lu = m_ex.valid && m_ex.mem_read && m_reads(m_ex.rd);
      bh = (is_branch_d || is_jalr_d) &&
           ((m_ex.valid && m_ex.reg_we && m_reads(m_ex.rd)) || (reg_we_m && mem_read_m && m_reads(rd_m)));
      return valid_d && (lu || bh);
   endfunction

   function automatic logic m_taken();
      logic [63:0] a, b;
      logic        slt, ult;
      a   = m_operand(instr_d[19:15]);
      b   = m_operand(instr_d[24:20]);
      slt = $signed(a) < $signed(b);
      ult = a < b;
      case (instr_d[14:12])
         3'd0:    return a == b;
         3'd1:    return !(a == b);
         3'd4:    return slt;
         3'd5:    return !slt;
         3'd6:    return ult;
         3'd7:    return !ult;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [63:0] m_target();
      if (is_jalr_d) return (m_operand(instr_d[19:15]) + imm_d) & ~64'd1;
      return pc_d + imm_d;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_ex();
      chk("valid_e", valid_e, m_ex.valid);
      chk("reg_we_e", reg_we_e, m_ex.reg_we);
      chk("mem_read_e", mem_read_e, m_ex.mem_read);
      chk("ctrl_e", ctrl_e, m_ex.ctrl);
      chk("rd_e", rd_e, m_ex.rd);
      chk("rs1_e", rs1_e, m_ex.rs1);
      chk("rs2_e", rs2_e, m_ex.rs2);
      chk("rd1_e", rd1_e, m_ex.rd1);
      chk("rd2_e", rd2_e, m_ex.rd2);
      chk("imm_e", imm_e, m_ex.imm);
      chk("pc_plus4_e", pc_plus4_e, m_ex.pc4);
   endtask

   // One cycle: check decode outputs at the falling edge, clock, check ID/EX.
   task automatic step();
      logic h, r;
      ex_t  nx;
      @(negedge clk);
      h = m_hazard();
      r = valid_d && !h && (is_jal_d || is_jalr_d || (is_branch_d && m_taken()));
      chk("stall_fd", stall_fd, h);
      chk("pc_src_d", pc_src_d, r);
      chk("flush_fd", flush_fd, r);
      if (r) chk("pc_target_d", pc_target_d, m_target());
      nx = '0;
      if (valid_d && !h && !flush_e) begin
         nx.valid = 1'b1;      nx.reg_we = reg_we_d;  nx.mem_read = mem_read_d;
         nx.ctrl  = ctrl_d;    nx.rd = instr_d[11:7];
         nx.rs1   = instr_d[19:15];  nx.rs2 = instr_d[24:20];
         nx.rd1   = m_read(instr_d[19:15]);  nx.rd2 = m_read(instr_d[24:20]);
         nx.imm   = imm_d;     nx.pc4 = pc_plus4_d;
      end
      @(posedge clk);
      if (reg_we_w && rd_w != 0) m_rf[rd_w] = result_w;
      m_ex = nx;
      #1;
      check_ex();
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
      m_ex = '0;
   endtask

   // ---------------- drivers ----------------
   task automatic idle();
      valid_d = 0; instr_d = 32'd0; pc_d = 0; pc_plus4_d = 0; imm_d = 0; ctrl_d = 0;
      reg_we_d = 0; mem_read_d = 0; use_rs1_d = 0; use_rs2_d = 0;
      is_branch_d = 0; is_jal_d = 0; is_jalr_d = 0;
      reg_we_m = 0; mem_read_m = 0; rd_m = 0; alu_result_m = 0;
      reg_we_w = 0; rd_w = 0; result_w = 0; flush_e = 0;
   endtask

   task automatic set_instr(input logic [4:0] s1, input logic [4:0] s2,
                            input logic [4:0] d, input logic [2:0] f3);
      instr_d = {7'h00, s2, s1, f3, d, 7'h63};
   endtask

   function automatic logic [63:0] pick_val();
      case ($urandom_range(0, 3))
         0:       return 64'd0;
         1:       return 64'($urandom_range(0, 3));
         2:       return ~64'd0;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic rand_inputs();
      int cls;
      valid_d = ($urandom_range(0, 7) != 0);
      instr_d = $urandom;
      instr_d[19:15] = 5'($urandom_range(0, 7));
      instr_d[24:20] = 5'($urandom_range(0, 7));
      instr_d[11:7]  = 5'($urandom_range(0, 7));
      pc_d = {$urandom, $urandom};
      pc_plus4_d = pc_d + 64'd4;
      imm_d = ($urandom_range(0, 1) == 1) ? 64'($signed(12'($urandom))) : {$urandom, $urandom};
      ctrl_d = 12'($urandom);
      reg_we_d = 1'($urandom);
      mem_read_d = reg_we_d && ($urandom_range(0, 2) == 0);
      use_rs1_d = 1'($urandom);
      use_rs2_d = 1'($urandom);
      cls = $urandom_range(0, 3);
      is_branch_d = (cls == 1); is_jal_d = (cls == 2); is_jalr_d = (cls == 3);
      reg_we_m = 1'($urandom); mem_read_m = 1'($urandom);
      rd_m = 5'($urandom_range(0, 7)); alu_result_m = pick_val();
      reg_we_w = 1'($urandom); rd_w = 5'($urandom_range(0, 7)); result_w = pick_val();
      flush_e = ($urandom_range(0, 9) == 0);
   endtask

   // ---------------- branch condition table ----------------
   typedef struct {
      logic [2:0]  f3;
      logic [63:0] a, b;
      logic        exp_taken;
   } br_vec_t;

   br_vec_t vecs [11];

   initial begin
      vecs[0]  = '{3'b000, 64'd5, 64'd5, 1'b1};
      vecs[1]  = '{3'b000, 64'd5, 64'd6, 1'b0};
      vecs[2]  = '{3'b001, 64'd5, 64'd6, 1'b1};
      vecs[3]  = '{3'b100, ~64'd0, 64'd1, 1'b1};
      vecs[4]  = '{3'b110, ~64'd0, 64'd1, 1'b0};
      vecs[5]  = '{3'b101, ~64'd0, 64'd1, 1'b0};
      vecs[6]  = '{3'b111, ~64'd0, 64'd1, 1'b1};
      vecs[7]  = '{3'b101, 64'd7, 64'd7, 1'b1};
      vecs[8]  = '{3'b110, 64'd1, ~64'd0, 1'b1};
      vecs[9]  = '{3'b010, 64'd1, 64'd2, 1'b0};
      vecs[10] = '{3'b011, 64'd0, 64'd0, 1'b0};

      // reset
      idle();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_valid_e", valid_e, 0);
      chk("reset_rd1_e", rd1_e, 0);
      check_ex();
      rst = 1'b0;

      // branch table: rs1 via MEM forward, rs2 via W bypass
      for (int i = 0; i < 11; i++) begin
         idle();
         valid_d = 1; is_branch_d = 1; use_rs1_d = 1; use_rs2_d = 1;
         set_instr(5'd1, 5'd2, 5'd0, vecs[i].f3);
         pc_d = 64'h400 + 64'(i * 4); imm_d = 64'h80;
         reg_we_m = 1; rd_m = 5'd1; alu_result_m = vecs[i].a;
         reg_we_w = 1; rd_w = 5'd2; result_w = vecs[i].b;
         #1;
         chk($sformatf("br_taken[%0d]", i), pc_src_d, vecs[i].exp_taken);
         if (vecs[i].exp_taken) chk($sformatf("br_target[%0d]", i), pc_target_d, 64'h480 + 64'(i * 4));
         step();
      end

      // W bypass
      idle();
      valid_d = 1; use_rs1_d = 1; reg_we_d = 1; set_instr(5'd3, 5'd0, 5'd10, 3'd0);
      reg_we_w = 1; rd_w = 5'd3; result_w = 64'h1234;
      step();
      chk("wbypass_rd1_e", rd1_e, 64'h1234);

      // load-use
      idle();
      valid_d = 1; reg_we_d = 1; mem_read_d = 1; set_instr(5'd0, 5'd0, 5'd5, 3'd3);
      step();
      idle();
      valid_d = 1; reg_we_d = 1; use_rs1_d = 1; set_instr(5'd5, 5'd0, 5'd6, 3'd0);
      #1 chk("lu_stall", stall_fd, 1);
      step();
      chk("lu_bubble_valid", valid_e, 0);
      chk("lu_bubble_we", reg_we_e, 0);
      reg_we_m = 1; mem_read_m = 1; rd_m = 5'd5;
      #1 chk("lu_release", stall_fd, 0);
      step();
      chk("lu_load_valid", valid_e, 1);
      chk("lu_load_rd", rd_e, 5'd6);

      // branch hazard then MEM forward
      idle();
      valid_d = 1; reg_we_d = 1; set_instr(5'd0, 5'd0, 5'd7, 3'd0);
      step();
      idle();
      valid_d = 1; is_branch_d = 1; use_rs1_d = 1; use_rs2_d = 1;
      set_instr(5'd7, 5'd0, 5'd0, 3'b000); pc_d = 64'h100; imm_d = 64'h40;
      #1;
      chk("bh_stall", stall_fd, 1);
      chk("bh_no_redirect", pc_src_d, 0);
      step();
      reg_we_m = 1; rd_m = 5'd7; alu_result_m = 64'd0;
      #1;
      chk("bh_release", stall_fd, 0);
      chk("bh_taken", pc_src_d, 1);
      chk("bh_target", pc_target_d, 64'h140);
      step();

      // MEM forwarding priority over W bypass, blt vs bltu
      idle();
      reg_we_w = 1; rd_w = 5'd2; result_w = 64'd1;
      step();
      idle();
      valid_d = 1; is_branch_d = 1; use_rs1_d = 1; use_rs2_d = 1;
      set_instr(5'd1, 5'd2, 5'd0, 3'b100); pc_d = 64'h2000; imm_d = 64'h20;
      reg_we_m = 1; rd_m = 5'd1; alu_result_m = ~64'd0;
      reg_we_w = 1; rd_w = 5'd1; result_w = 64'd5;
      #1;
      chk("blt_taken", pc_src_d, 1);
      chk("blt_target", pc_target_d, 64'h2020);
      step();
      reg_we_w = 0;
      set_instr(5'd1, 5'd2, 5'd0, 3'b110);
      #1 chk("bltu_not_taken", pc_src_d, 0);
      step();

      // JALR
      idle();
      valid_d = 1; is_jalr_d = 1; use_rs1_d = 1; reg_we_d = 1;
      set_instr(5'd9, 5'd0, 5'd1, 3'd0); imm_d = 64'd4; pc_d = 64'h3000; pc_plus4_d = 64'h3004;
      reg_we_w = 1; rd_w = 5'd9; result_w = 64'h1001;
      #1;
      chk("jalr_target", pc_target_d, 64'h1004);
      chk("jalr_flush_fd", flush_fd, 1);
      step();
      chk("jalr_valid_e", valid_e, 1);
      chk("jalr_reg_we_e", reg_we_e, 1);
      chk("jalr_pc4_e", pc_plus4_e, 64'h3004);

      // flush_e on a valid load, then flush_e together with a hazard
      idle();
      valid_d = 1; reg_we_d = 1; ctrl_d = 12'hABC; set_instr(5'd0, 5'd0, 5'd4, 3'd0); flush_e = 1;
      step();
      chk("flush_valid_e", valid_e, 0);
      chk("flush_ctrl_e", ctrl_e, 0);
      idle();
      valid_d = 1; reg_we_d = 1; mem_read_d = 1; set_instr(5'd0, 5'd0, 5'd5, 3'd3);
      step();
      idle();
      valid_d = 1; use_rs1_d = 1; reg_we_d = 1; set_instr(5'd5, 5'd0, 5'd6, 3'd0); flush_e = 1;
      #1 chk("flush_hz_stall", stall_fd, 1);
      step();
      chk("flush_hz_valid_e", valid_e, 0);

      // randomized against the model
      for (int n = 0; n < 600; n++) begin
         rand_inputs();
         step();
      end

      // reset in the middle of a load-use stall
      idle();
      valid_d = 1; reg_we_d = 1; mem_read_d = 1; set_instr(5'd0, 5'd0, 5'd5, 3'd3);
      step();
      idle();
      valid_d = 1; use_rs1_d = 1; set_instr(5'd5, 5'd0, 5'd0, 3'd0);
      #1 chk("pre_rst_stall", stall_fd, 1);
      rst = 1'b1;
      #1;
      model_reset();
      chk("rst_stall_released", stall_fd, 0);
      chk("rst_pc_src", pc_src_d, 0);
      chk("rst_valid_e", valid_e, 0);
      check_ex();
      rst = 1'b0;
      #1;
      step();

      for (int r = 1; r < 32; r++) begin
         idle();
         valid_d = 1; use_rs1_d = 1; use_rs2_d = 1; set_instr(5'(r), 5'(r), 5'd0, 3'd0);
         step();
         chk($sformatf("rst_x%0d", r), rd1_e, 64'd0);
      end

      // x0 stays zero
      idle();
      valid_d = 1; use_rs1_d = 1; set_instr(5'd0, 5'd0, 5'd0, 3'd0);
      reg_we_w = 1; rd_w = 5'd0; result_w = 64'd5;
      step();
      chk("x0_bypass", rd1_e, 64'd0);
      reg_we_w = 0;
      step();
      chk("x0_read", rd1_e, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
